// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store request and response channel between the MEM stage and data memory
interface dmem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_write;
  logic [DATA_WIDTH-1:0]   req_data;
  logic [DATA_WIDTH/8-1:0] req_strb;
  logic [2:0]              req_size;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    rsp_error;

  modport master (
    output req_valid, req_addr, req_write, req_data, req_strb, req_size, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_error
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_data, req_strb, req_size, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_error
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data memory responder with byte strobes and programmable latency
// Optional alignment checking is enabled by defining DMEM_MISALIGN_ERR_EN.
module dmem_responder #(
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           MEM_DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h0001_0000,
  parameter int unsigned           RSP_LATENCY     = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  dmem_responder_if.slave  bus
);

  localparam int unsigned           IDX_W  = $clog2(MEM_DEPTH_WORDS);
  localparam int unsigned           STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   SPAN   = (ADDR_WIDTH + 1)'(MEM_DEPTH_WORDS * 4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                state, state_d;
  logic [3:0]            cnt, cnt_d;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_error_q;

  logic [ADDR_WIDTH-1:0] off;
  logic [IDX_W-1:0]      idx;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  acc_err;
  logic                  accept;

  // Modular offset: addresses below the base wrap high and also fail the span compare.
  assign off          = bus.req_addr - BASE_ADDR;
  assign idx          = off[IDX_W+1:2];
  assign out_of_range = (bus.req_addr < BASE_ADDR) || ({1'b0, off} >= SPAN);

`ifdef DMEM_MISALIGN_ERR_EN
  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size)
      3'd0:    misaligned = 1'b0;
      3'd1:    misaligned = bus.req_addr[0];
      3'd2:    misaligned = |bus.req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end
`else
  logic unused_size;
  assign misaligned  = 1'b0;
  assign unused_size = ^bus.req_size;
`endif

  assign acc_err = out_of_range || misaligned;
  assign accept  = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (RSP_LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(RSP_LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt - 4'd1;
        if (cnt == 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == S_IDLE);
    bus.rsp_valid = (state == S_RESP);
    bus.rsp_data  = rsp_data_q;
    bus.rsp_error = rsp_error_q;
  end

  // Response payload is captured at accept so later req_* activity cannot disturb it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else if (accept) begin
      rsp_error_q <= acc_err;
      rsp_data_q  <= (acc_err || bus.req_write) ? '0 : mem[idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && bus.req_write && !acc_err) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (bus.req_strb[i]) mem[idx][8*i +: 8] <= bus.req_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder at response latencies 1 and 4
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT [2] = '{1, 4};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0]  req_valid = 2'b00;
  logic [31:0] req_addr  = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_strb  = '0;
  logic [2:0]  req_size  = '0;
  logic        rsp_ready = 1'b0;

  logic        rv [2];
  logic        rr [2];
  logic        re [2];
  logic [31:0] rd [2];

  dmem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
  dmem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus4 ();

  assign bus1.req_valid = req_valid[0];
  assign bus4.req_valid = req_valid[1];
  assign bus1.req_addr  = req_addr;   assign bus4.req_addr  = req_addr;
  assign bus1.req_write = req_write;  assign bus4.req_write = req_write;
  assign bus1.req_data  = req_data;   assign bus4.req_data  = req_data;
  assign bus1.req_strb  = req_strb;   assign bus4.req_strb  = req_strb;
  assign bus1.req_size  = req_size;   assign bus4.req_size  = req_size;
  assign bus1.rsp_ready = rsp_ready;  assign bus4.rsp_ready = rsp_ready;

  assign rv[0] = bus1.rsp_valid;  assign rv[1] = bus4.rsp_valid;
  assign rr[0] = bus1.req_ready;  assign rr[1] = bus4.req_ready;
  assign re[0] = bus1.rsp_error;  assign re[1] = bus4.rsp_error;
  assign rd[0] = bus1.rsp_data;   assign rd[1] = bus4.rsp_data;

  dmem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RSP_LATENCY(1)
  ) u_dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave));

  dmem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RSP_LATENCY(4)
  ) u_dut4 (.clk_i(clk), .rst_ni(rst_n), .bus(bus4.slave));

  // Reference memory: one word per (instance, word index); missing entries are unwritten.
  logic [31:0] mdl [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_access(input int sel, input logic [31:0] addr, input logic wr,
                              input logic [31:0] data, input logic [3:0] strb, input logic [2:0] size,
                              output logic [31:0] exp_d, output logic exp_e);
    longint      a;
    int          key;
    logic [31:0] w;
    a     = longint'(addr);
    exp_e = (a < longint'(BASE)) || (a >= longint'(BASE) + DEPTH * 4);
`ifdef DMEM_MISALIGN_ERR_EN
    if ((size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00) || size > 3'd2) exp_e = 1'b1;
`else
    if (size > 3'd7) exp_e = 1'b1;
`endif
    exp_d = '0;
    if (!exp_e) begin
      key = sel * DEPTH + int'((a - longint'(BASE)) / 4);
      w   = mdl.exists(key) ? mdl[key] : 'x;
      if (wr) begin
        for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
        mdl[key] = w;
      end else begin
        exp_d = w;
      end
    end
  endtask

  task automatic txn(input int sel, input logic [31:0] addr, input logic wr, input logic [31:0] data,
                     input logic [3:0] strb, input logic [2:0] size, input int hold,
                     output logic [31:0] rdata, output logic err);
    int cyc;
    @(negedge clk);
    check("ready_idle", 32'(rr[sel]), 32'd1);
    req_addr = addr; req_write = wr; req_data = data; req_strb = strb; req_size = size;
    req_valid[sel] = 1'b1;
    @(posedge clk); #1;
    req_valid[sel] = 1'b0;
    req_addr = $urandom; req_write = 1'($urandom); req_data = $urandom;
    req_strb = 4'($urandom); req_size = 3'($urandom);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!rv[sel]) check("ready_wait", 32'(rr[sel]), 32'd0);
    end while (!rv[sel] && cyc < 40);
    check("latency", 32'(cyc), 32'(LAT[sel]));
    rdata = rd[sel];
    err   = re[sel];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("held_valid", 32'(rv[sel]), 32'd1);
      check("held_data", rd[sel], rdata);
      check("held_err", 32'(re[sel]), 32'(err));
    end
    rsp_ready = 1'b1;
    check("ready_in_hs", 32'(rr[sel]), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("valid_after_hs", 32'(rv[sel]), 32'd0);
    check("ready_after_hs", 32'(rr[sel]), 32'd1);
  endtask

  task automatic do_chk(input string tag, input int sel, input logic [31:0] addr, input logic wr,
                        input logic [31:0] data, input logic [3:0] strb, input logic [2:0] size,
                        input int hold, output logic [31:0] rdata, output logic err);
    logic [31:0] exp_d;
    logic        exp_e;
    model_access(sel, addr, wr, data, strb, size, exp_d, exp_e);
    txn(sel, addr, wr, data, strb, size, hold, rdata, err);
    check({tag, "_err"}, 32'(err), 32'(exp_e));
    check({tag, "_data"}, rdata, exp_d);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic [31:0] a;
    logic [31:0] oor_lo;
    logic [31:0] oor_hi;

    // Reset held for three cycles, then idle.
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      for (int s = 0; s < 2; s++) begin
        check("rst_ready", 32'(rr[s]), 32'd1);
        check("rst_valid", 32'(rv[s]), 32'd0);
        check("rst_err", 32'(re[s]), 32'd0);
      end
    end

    // Store then load at latency 1.
    do_chk("sw10", 0, 32'h0001_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'd2, 0, d, e);
    do_chk("lw10", 0, 32'h0001_0010, 1'b0, 32'h0, 4'h0, 3'd2, 0, d, e);
    check("lw10_const", d, 32'hDEAD_BEEF);

    // Single-lane strobe merge.
    do_chk("sw20", 0, 32'h0001_0020, 1'b1, 32'h1122_3344, 4'hF, 3'd2, 1, d, e);
    do_chk("sb20", 0, 32'h0001_0020, 1'b1, 32'h00AA_0000, 4'b0100, 3'd0, 0, d, e);
    do_chk("lw20", 0, 32'h0001_0020, 1'b0, 32'h0, 4'hF, 3'd2, 2, d, e);
    check("lw20_const", d, 32'h11AA_3344);

    // Latency 4 with five cycles of back-pressure.
    do_chk("sw30_l4", 1, 32'h0001_0030, 1'b1, 32'h5566_7788, 4'hF, 3'd2, 0, d, e);
    do_chk("lw30_l4", 1, 32'h0001_0030, 1'b0, 32'h0, 4'h0, 3'd2, 5, d, e);
    check("lw30_l4_const", d, 32'h5566_7788);

    // Range boundaries.
    do_chk("sw_last", 0, 32'h0001_0FFC, 1'b1, 32'hA5A5_0FFC, 4'hF, 3'd2, 0, d, e);
    do_chk("lw_last", 0, 32'h0001_0FFC, 1'b0, 32'h0, 4'h0, 3'd2, 0, d, e);
    check("lw_last_const_err", 32'(e), 32'd0);
    do_chk("lw_end", 0, 32'h0001_1000, 1'b0, 32'h0, 4'h0, 3'd2, 0, d, e);
    check("lw_end_const_err", 32'(e), 32'd1);
    check("lw_end_const_data", d, 32'h0);
    do_chk("sw_below", 0, 32'h0000_FFFC, 1'b1, 32'hBAD0_BAD0, 4'hF, 3'd2, 0, d, e);
    check("sw_below_const_err", 32'(e), 32'd1);
    do_chk("lw_wrap", 0, 32'hFFFF_FFFC, 1'b0, 32'h0, 4'h0, 3'd2, 0, d, e);
    do_chk("rd10_after", 0, 32'h0001_0010, 1'b0, 32'h0, 4'h0, 3'd2, 0, d, e);
    do_chk("rd20_after", 0, 32'h0001_0020, 1'b0, 32'h0, 4'h0, 3'd2, 0, d, e);
    do_chk("rdffc_after", 0, 32'h0001_0FFC, 1'b0, 32'h0, 4'h0, 3'd2, 0, d, e);

    // Misaligned halfword load.
    do_chk("lh11", 0, 32'h0001_0011, 1'b0, 32'h0, 4'h0, 3'd1, 0, d, e);
`ifdef DMEM_MISALIGN_ERR_EN
    check("lh11_const_err", 32'(e), 32'd1);
`else
    check("lh11_const_data", d, 32'hDEAD_BEEF);
`endif

    // Reset in WAIT after a store accept: no response, store stays committed.
    @(negedge clk);
    req_addr = 32'h0001_0040; req_write = 1'b1; req_data = 32'hCAFE_F00D; req_strb = 4'hF; req_size = 3'd2;
    req_valid[1] = 1'b1;
    model_access(1, 32'h0001_0040, 1'b1, 32'hCAFE_F00D, 4'hF, 3'd2, d, e);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("mid_wait_valid", 32'(rv[1]), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(rv[1]), 32'd0);
      check("post_rst_ready", 32'(rr[1]), 32'd1);
    end
    do_chk("lw40_l4", 1, 32'h0001_0040, 1'b0, 32'h0, 4'h0, 3'd2, 0, d, e);
    check("lw40_const", d, 32'hCAFE_F00D);

    // Randomized traffic over a pre-initialised 16-word window plus out-of-range probes.
    oor_lo = BASE - 32'd4;
    oor_hi = BASE + 32'(DEPTH * 4);
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 16; w++)
        do_chk("init", s, BASE + 32'h400 + 32'(w * 4), 1'b1, $urandom, 4'hF, 3'd2, 0, d, e);
    for (int n = 0; n < 120; n++) begin
      int sel;
      int r;
      sel = n % 2;
      r   = $urandom_range(0, 9);
      if (r == 0)      a = oor_lo + 32'($urandom_range(0, 3));
      else if (r == 1) a = oor_hi + 32'($urandom_range(0, 3));
      else             a = BASE + 32'h400 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      do_chk("rand", sel, a, 1'($urandom), $urandom, 4'($urandom), 3'($urandom_range(0, 3)),
             $urandom_range(0, 3), d, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
